// File: rtl/timing_pkg.sv
// Shared types and defaults for the timing_cells reference storage elements.
package timing_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    JK_HOLD,
    JK_CLR,
    JK_SET,
    JK_TGL
  } jk_op_t;

  function automatic jk_op_t jk_decode(input logic j, input logic k);
    jk_op_t op;
    case ({j, k})
      2'b10:   op = JK_SET;
      2'b01:   op = JK_CLR;
      2'b11:   op = JK_TGL;
      default: op = JK_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/timing_cnt.sv
// Enabled up-counter with async active-low clear.
// TIMING_I_SAT_EN defined: saturates at all-ones; otherwise wraps to zero.
module timing_cnt
  import timing_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
`ifdef TIMING_I_SAT_EN
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`else
      r_cnt <= r_cnt + 1'b1;
`endif
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/timing_cells.sv
// Reference set of basic storage elements (latch, edge flops, JK, T, set/clear,
// edge detect, counter, shift register). Optional macro: TIMING_I_SAT_EN.
module timing_cells
  import timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             X,
  input  logic             Y,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             E,
  output logic             F,
  output logic             G,
  output logic             H,
  output logic [CNT_W-1:0] I,
  output logic [CNT_W-1:0] J
);

  logic             r_a;
  logic             r_b;
  logic             r_c;
  logic             r_d;
  logic             r_e;
  logic             r_f;
  logic             r_g;
  logic             r_h;
  logic             r_xq;
  logic [CNT_W-1:0] r_j;
  logic [CNT_W-1:0] w_cnt;

  jk_op_t           w_jk_op;
  logic             w_e_nxt;
  logic             w_f_nxt;
  logic             w_g_nxt;

  // Transparent-high latch; the only output that follows X between edges.
  always_latch begin
    if (!R) begin
      r_a <= 1'b0;
    end else if (CLK) begin
      r_a <= X;
    end
  end

  always_ff @(negedge CLK or negedge R) begin
    if (!R) begin
      r_c <= 1'b0;
    end else begin
      r_c <= X;
    end
  end

  always_comb begin
    w_jk_op = jk_decode(X, Y);
    w_e_nxt = r_e;
    case (w_jk_op)
      JK_SET:  w_e_nxt = 1'b1;
      JK_CLR:  w_e_nxt = 1'b0;
      JK_TGL:  w_e_nxt = ~r_e;
      default: w_e_nxt = r_e;
    endcase

    w_f_nxt = r_f ^ X;

    // Clear dominates when both set and clear are asserted.
    w_g_nxt = r_g;
    if (Y) begin
      w_g_nxt = 1'b0;
    end else if (X) begin
      w_g_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_b  <= 1'b0;
      r_d  <= 1'b0;
      r_e  <= 1'b0;
      r_f  <= 1'b0;
      r_g  <= 1'b0;
      r_h  <= 1'b0;
      r_xq <= 1'b0;
      r_j  <= '0;
    end else begin
      r_b  <= X;
      r_d  <= X & Y;
      r_e  <= w_e_nxt;
      r_f  <= w_f_nxt;
      r_g  <= w_g_nxt;
      r_h  <= X & ~r_xq;
      r_xq <= X;
      r_j  <= {r_j[CNT_W-2:0], Y};
    end
  end

  timing_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .i_clk   (CLK),
    .i_rst_n (R),
    .i_en    (X),
    .o_cnt   (w_cnt)
  );

  assign A = r_a;
  assign B = r_b;
  assign C = r_c;
  assign D = r_d;
  assign E = r_e;
  assign F = r_f;
  assign G = r_g;
  assign H = r_h;
  assign I = w_cnt;
  assign J = r_j;

endmodule

// File: tb/tb_timing_cells.sv
// Self-checking bench for timing_cells: directed scenarios plus random X/Y
// checked against a behavioural model of each storage element.
module tb_timing_cells;

  logic        CLK;
  logic        R;
  logic        X;
  logic        Y;
  logic        A, B, C, D, E, F, G, H;
  logic [15:0] I;
  logic [15:0] J;

  int n_tests;
  int n_fail;

  logic m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h, m_xq;
  int   m_i, m_j;

  timing_cells #(.CNT_W(16)) dut (
    .CLK (CLK), .R (R), .X (X), .Y (Y),
    .A (A), .B (B), .C (C), .D (D), .E (E), .F (F), .G (G), .H (H),
    .I (I), .J (J)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_e = 0; m_f = 0; m_g = 0; m_h = 0;
    m_xq = 0; m_i = 0; m_j = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_A"}, {31'd0, A}, {31'd0, m_a});
    chk({tag, "_B"}, {31'd0, B}, {31'd0, m_b});
    chk({tag, "_C"}, {31'd0, C}, {31'd0, m_c});
    chk({tag, "_D"}, {31'd0, D}, {31'd0, m_d});
    chk({tag, "_E"}, {31'd0, E}, {31'd0, m_e});
    chk({tag, "_F"}, {31'd0, F}, {31'd0, m_f});
    chk({tag, "_G"}, {31'd0, G}, {31'd0, m_g});
    chk({tag, "_H"}, {31'd0, H}, {31'd0, m_h});
    chk({tag, "_I"}, {16'd0, I}, m_i);
    chk({tag, "_J"}, {16'd0, J}, m_j);
  endtask

  // Apply X/Y, take one rising edge, update the model, optionally check.
  // Returns 2 time units after the edge with CLK still high.
  task automatic step(input logic x, input logic y, input bit do_chk, input string tag);
    X = x;
    Y = y;
    if (CLK) m_c = x;
    @(posedge CLK);
    m_b = x;
    m_d = x & y;
    if (x && y)  m_e = ~m_e;
    else if (x)  m_e = 1'b1;
    else if (y)  m_e = 1'b0;
    m_f = m_f ^ x;
    if (y)       m_g = 1'b0;
    else if (x)  m_g = 1'b1;
    m_h  = x & ~m_xq;
    m_xq = x;
    if (x) begin
`ifdef TIMING_I_SAT_EN
      if (m_i != 65535) m_i = m_i + 1;
`else
      m_i = (m_i + 1) % 65536;
`endif
    end
    m_j = ((m_j * 2) + int'(y)) % 65536;
    #1;
    m_a = x;
    if (do_chk) check_all(tag);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();

    // 1: reset held with X=Y=1 and the clock running
    R = 1'b0; X = 1'b1; Y = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check_all("rst_hi");
      @(negedge CLK); #1;
      check_all("rst_lo");
    end

    // 2: release with CLK low, X=1 Y=0 for three edges
    R = 1'b1;
    step(1, 0, 1, "t2_e1");
    chk("t2_H1", {31'd0, H}, 32'd1);
    step(1, 0, 1, "t2_e2");
    chk("t2_F2", {31'd0, F}, 32'd0);
    chk("t2_H2", {31'd0, H}, 32'd0);
    step(1, 0, 1, "t2_e3");
    chk("t2_I",  {16'd0, I}, 32'd3);
    chk("t2_F3", {31'd0, F}, 32'd1);
    chk("t2_G",  {31'd0, G}, 32'd1);
    chk("t2_B",  {31'd0, B}, 32'd1);

    // 3: JK toggle from E=0
    step(0, 1, 1, "t3_clr");
    step(1, 1, 1, "t3_e1");
    chk("t3_E1", {31'd0, E}, 32'd1);
    step(1, 1, 1, "t3_e2");
    chk("t3_E2", {31'd0, E}, 32'd0);
    chk("t3_G",  {31'd0, G}, 32'd0);
    chk("t3_D",  {31'd0, D}, 32'd1);

    // 4: flush J then shift 1,0,1,1
    for (int k = 0; k < 16; k++) step(0, 0, 0, "t4_flush");
    chk("t4_J0", {16'd0, J}, 32'd0);
    step(0, 1, 1, "t4_s1");
    step(0, 0, 1, "t4_s2");
    step(0, 1, 1, "t4_s3");
    step(0, 1, 1, "t4_s4");
    chk("t4_J", {16'd0, J}, 32'h000B);

    // 5: X pulse raised while CLK=1, dropped after the falling edge
    X = 1'b1;
    #1;
    chk("t5_A_open", {31'd0, A}, 32'd1);
    @(negedge CLK); #1;
    m_a = 1'b1;
    m_c = 1'b1;
    X = 1'b0;
    #1;
    chk("t5_A_hold", {31'd0, A}, 32'd1);
    chk("t5_C",      {31'd0, C}, 32'd1);
    chk("t5_B",      {31'd0, B}, {31'd0, m_b});
    chk("t5_I",      {16'd0, I}, m_i);
    step(0, 0, 1, "t5_after");

    // random X/Y against the model
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, "rnd");
    end

    // 6: counter boundary, then reset mid-count
    while (m_i != 65535) step(1, 1'($urandom_range(0, 1)), 0, "t6_fill");
    check_all("t6_full");
    chk("t6_I_full", {16'd0, I}, 32'h0000FFFF);
    step(1, 0, 1, "t6_over");
`ifdef TIMING_I_SAT_EN
    chk("t6_I_over", {16'd0, I}, 32'h0000FFFF);
`else
    chk("t6_I_over", {16'd0, I}, 32'h00000000);
`endif
    step(1, 1, 1, "t6_more");
    step(1, 0, 1, "t6_more");
    R = 1'b0;
    model_clear();
    #1;
    check_all("t6_rst_now");
    chk("t6_I_rst", {16'd0, I}, 32'd0);
    @(negedge CLK); #1;
    check_all("t6_rst_lo");
    R = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, "t6_post");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
